// File: rtl/chan_mux_seq.sv
// Registered N:1 channel selector: manual select or round-robin scan over an enable mask.
// Latency: 1 cycle from a load-slot edge to out_data; 2 cycles from an en/mode change to the first capture.
// Backpressure: out_data/out_ch hold while out_valid && !out_ready; a new capture replaces an accepted sample with no bubble.
module chan_mux_seq #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           mode,
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel_in,
    input  logic [N-1:0]   en_mask,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sel_err,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic          sel_err_q, sel_err_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_slot;
    logic          sel_ok;
    logic          scan_hit;
    logic [SW-1:0] scan_ch;
    logic [SW:0]   idx;
    logic [SW:0]   ptr_nxt;

    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode ? SCAN : MAN;
        end
    end

    // Walk offsets from far to near so the nearest enabled channel at or after ptr wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = '0;
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (SW+1)'(i);
            if (idx >= (SW+1)'(N)) begin
                idx = idx - (SW+1)'(N);
            end
            if (en_mask[idx[SW-1:0]]) begin
                scan_hit = 1'b1;
                scan_ch  = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        load_slot   = !out_valid_q || out_ready;
        sel_ok      = ({1'b0, sel_in} < (SW+1)'(N));
        ptr_nxt     = {1'b0, scan_ch} + (SW+1)'(1);
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q && !out_ready;
        sel_err_d   = 1'b0;
        ptr_d       = ptr_q;

        case (state_q)
            MAN: begin
                if (load_slot) begin
                    if (sel_ok) begin
                        out_data_d  = din[sel_in*W +: W];
                        out_ch_d    = sel_in;
                        out_valid_d = 1'b1;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (load_slot && scan_hit) begin
                    out_data_d  = din[scan_ch*W +: W];
                    out_ch_d    = scan_ch;
                    out_valid_d = 1'b1;
                    ptr_d       = (ptr_nxt == (SW+1)'(N)) ? '0 : ptr_nxt[SW-1:0];
                end
            end
            default: begin
            end
        endcase

        // Every entry into SCAN restarts the sweep at channel 0.
        if (state_d == SCAN && state_q != SCAN) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chan_mux_seq.sv
// Directed bench for chan_mux_seq: an N=8 instance for manual/scan/backpressure/reset and an N=6 instance for out-of-range selects.
module tb_chan_mux_seq;

    logic        clk;
    logic        rst_n;

    logic        en, mode, out_ready;
    logic [63:0] din;
    logic [2:0]  sel_in;
    logic [7:0]  en_mask;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid, sel_err, busy;

    logic        en6, mode6, ready6;
    logic [47:0] din6;
    logic [2:0]  sel6;
    logic [5:0]  mask6;
    logic [7:0]  o6_data;
    logic [2:0]  o6_ch;
    logic        o6_valid, o6_err, o6_busy;

    int n_checks = 0;
    int n_fail   = 0;

    chan_mux_seq #(.N(8), .W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .din       (din),
        .sel_in    (sel_in),
        .en_mask   (en_mask),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .busy      (busy)
    );

    chan_mux_seq #(.N(6), .W(8)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en6),
        .mode      (mode6),
        .din       (din6),
        .sel_in    (sel6),
        .en_mask   (mask6),
        .out_data  (o6_data),
        .out_ch    (o6_ch),
        .out_valid (o6_valid),
        .out_ready (ready6),
        .sel_err   (o6_err),
        .busy      (o6_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] ch, input logic [7:0] d);
        chk({tag, ".vld"},  32'(out_valid), 32'(v));
        chk({tag, ".ch"},   32'(out_ch),    32'(ch));
        chk({tag, ".data"}, 32'(out_data),  32'(d));
    endtask

    task automatic chk_out6(input string tag, input logic v, input logic err, input logic [2:0] ch, input logic [7:0] d);
        chk({tag, ".vld"},  32'(o6_valid), 32'(v));
        chk({tag, ".err"},  32'(o6_err),   32'(err));
        chk({tag, ".ch"},   32'(o6_ch),    32'(ch));
        chk({tag, ".data"}, 32'(o6_data),  32'(d));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mseq [7];
        mseq = '{7, 0, 2, 7, 0, 2, 7};

        rst_n     = 1'b1;
        en        = 1'b1;
        mode      = 1'b0;
        sel_in    = 3'd5;
        en_mask   = 8'hFF;
        out_ready = 1'b1;
        en6       = 1'b0;
        mode6     = 1'b0;
        sel6      = 3'd0;
        mask6     = 6'h3F;
        ready6    = 1'b1;
        for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'(16 + k);
        for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(16 + k);

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk_out("rst", 1'b0, 3'd0, 8'h00);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.err", 32'(sel_err), 32'd0);
        chk("rst6.vld", 32'(o6_valid), 32'd0);

        // Manual select: first sample on the second edge after release
        #10 rst_n = 1'b1;
        tick;
        chk("man.busy", 32'(busy), 32'd1);
        chk("man.first_vld", 32'(out_valid), 32'd0);
        tick;
        chk_out("man5", 1'b1, 3'd5, 8'h15);
        for (int k = 0; k < 8; k++) begin
            sel_in = 3'(k);
            tick;
            chk_out("man_sweep", 1'b1, 3'(k), 8'(16 + k));
        end
        chk("man.err", 32'(sel_err), 32'd0);

        // Mode switch: one more MAN capture, then SCAN from channel 0
        mode = 1'b1;
        tick;
        chk_out("mode_sw", 1'b1, 3'd7, 8'h17);
        tick;
        chk_out("scan0", 1'b1, 3'd0, 8'h10);

        // Backpressure
        out_ready = 1'b0;
        repeat (4) begin
            tick;
            chk_out("bp_hold", 1'b1, 3'd0, 8'h10);
        end
        out_ready = 1'b1;
        tick;
        chk_out("bp_rel1", 1'b1, 3'd1, 8'h11);
        tick;
        chk_out("bp_rel2", 1'b1, 3'd2, 8'h12);

        // Masked scan with wrap, continuing from ptr=3
        en_mask = 8'b1000_0101;
        for (int k = 0; k < 7; k++) begin
            tick;
            chk_out("mask", 1'b1, 3'(mseq[k]), 8'(16 + mseq[k]));
        end

        // Empty mask: valid drops, contents retained
        en_mask = 8'h00;
        repeat (3) begin
            tick;
            chk_out("empty", 1'b0, 3'd7, 8'h17);
        end
        en_mask = 8'h08;
        repeat (3) begin
            tick;
            chk_out("m08", 1'b1, 3'd3, 8'h13);
        end

        // Out-of-range select on the N=6 instance
        en6  = 1'b1;
        sel6 = 3'd2;
        tick;
        chk("n6.busy", 32'(o6_busy), 32'd1);
        tick;
        chk_out6("n6.sel2", 1'b1, 1'b0, 3'd2, 8'h12);
        ready6 = 1'b0;
        sel6   = 3'd7;
        tick;
        chk_out6("n6.stall", 1'b1, 1'b0, 3'd2, 8'h12);
        ready6 = 1'b1;
        tick;
        chk_out6("n6.err1", 1'b0, 1'b1, 3'd2, 8'h12);
        tick;
        chk_out6("n6.err2", 1'b0, 1'b1, 3'd2, 8'h12);
        sel6 = 3'd4;
        tick;
        chk_out6("n6.sel4", 1'b1, 1'b0, 3'd4, 8'h14);

        // Asynchronous reset mid-scan
        en_mask = 8'hFF;
        tick;
        chk_out("pre_rst", 1'b1, 3'd4, 8'h14);
        #3 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 3'd0, 8'h00);
        chk("async_rst.busy", 32'(busy), 32'd0);
        chk("async_rst.err", 32'(sel_err), 32'd0);
        chk_out6("async_rst6", 1'b0, 1'b0, 3'd0, 8'h00);
        chk("async_rst6.busy", 32'(o6_busy), 32'd0);
        #2 rst_n = 1'b1;
        tick;
        chk("restart.busy", 32'(busy), 32'd1);
        chk("restart.vld", 32'(out_valid), 32'd0);
        tick;
        chk_out("restart0", 1'b1, 3'd0, 8'h10);
        tick;
        chk_out("restart1", 1'b1, 3'd1, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
